// File: rtl/adc_frame_spi_master.sv
`timescale 1ns/1ps
// Mode-0 SPI master that sends one 2-byte ADC frame per request
// ({sample[7:0]}, {channel, 2'b00, sample[9:8]}) and captures the MISO bytes alongside.
module adc_frame_spi_master #(
    parameter int SCK_HALF = 4,
    parameter int SS_GAP   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_data,
    input  logic [9:0]  sample,
    input  logic [3:0]  sample_channel,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_data,
    output logic        ss,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);
    // state | meaning
    // IDLE  | ss high, waiting for new_data
    // SETUP | ss low, sck low for SCK_HALF cycles before the first rising edge
    // SHIFT | 16 bits, each SCK_HALF cycles high then SCK_HALF cycles low
    // HOLD  | ss low, sck low for SCK_HALF cycles after the last falling edge
    // GAP   | ss high; busy drops after SS_GAP cycles, IDLE follows one cycle later
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int CNT_MAX = (SCK_HALF > SS_GAP) ? SCK_HALF : SS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(SCK_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(SS_GAP);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]       r_bit, w_bit_nxt;
    logic [15:0]      r_shift, w_shift_nxt;
    logic [15:0]      r_cap, w_cap_nxt;
    logic [15:0]      r_rx, w_rx_nxt;
    logic             r_ss, w_ss_nxt;
    logic             r_sck, w_sck_nxt;
    logic             r_mosi, w_mosi_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_cap   <= '0;
            r_rx    <= '0;
            r_ss    <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_cap   <= w_cap_nxt;
            r_rx    <= w_rx_nxt;
            r_ss    <= w_ss_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_cap_nxt   = r_cap;
        w_rx_nxt    = r_rx;
        w_ss_nxt    = r_ss;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (new_data) begin
                    w_state_nxt = SETUP;
                    w_shift_nxt = {sample[7:0], sample_channel, 2'b00, sample[9:8]};
                    w_mosi_nxt  = sample[7];
                    w_ss_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = HALF_LOAD;
                    w_bit_nxt   = '0;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SHIFT;
                    w_sck_nxt   = 1'b1;
                    w_cap_nxt   = {r_cap[14:0], miso};
                    w_cnt_nxt   = HALF_LOAD;
                end
            end
            SHIFT: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt = HALF_LOAD;
                    if (r_sck) begin
                        w_sck_nxt = 1'b0;
                        w_bit_nxt = r_bit + 5'd1;
                        if (r_bit == 5'd15) begin
                            w_state_nxt = HOLD;
                            w_mosi_nxt  = 1'b0;
                        end else begin
                            w_mosi_nxt  = r_shift[14];
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                        end
                    end else begin
                        w_sck_nxt = 1'b1;
                        w_cap_nxt = {r_cap[14:0], miso};
                    end
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = GAP;
                    w_ss_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_rx_nxt    = r_cap;
                    w_cnt_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                // busy is registered, so it is cleared one count early to fall exactly at the gap end
                if (r_cnt == CNT_W'(1)) w_busy_nxt = 1'b0;
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx;
    assign ss      = r_ss;
    assign sck     = r_sck;
    assign mosi    = r_mosi;
endmodule

// File: tb/tb_adc_frame_spi_master.sv
`timescale 1ns/1ps
// Bench for adc_frame_spi_master: three instances (default, fast, slow parameters),
// a mode-0 slave model per instance and a frame scoreboard checked at each ss rise.
module tb_adc_frame_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic        nd[3];
    logic [9:0]  smp[3];
    logic [3:0]  ch[3];
    logic        rst_v[3];
    logic        miso_w[3];
    logic        busy_w[3];
    logic        done_w[3];
    logic [15:0] rx_w[3];
    logic        ss_w[3];
    logic        sck_w[3];
    logic        mosi_w[3];
    logic [15:0] miso_pat[3];
    logic [15:0] rx_prev[3];
    logic        abort_exp[3];
    logic [15:0] exp_q[3][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int hh(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 7);
    endfunction

    function automatic int gg(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 1 : 20);
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int H = (i == 0) ? 4 : ((i == 1) ? 2 : 7);
        localparam int G = (i == 0) ? 8 : ((i == 1) ? 1 : 20);
        logic [15:0] s_sh = '0;
        logic [15:0] mo_sh = '0;
        int nrise = 0;
        int t_fall = 0;
        logic p_ss = 1'b1;
        logic p_sck = 1'b0;

        adc_frame_spi_master #(.SCK_HALF(H), .SS_GAP(G)) u_dut (
            .clk            (clk),
            .rst            (rst_v[i]),
            .new_data       (nd[i]),
            .sample         (smp[i]),
            .sample_channel (ch[i]),
            .busy           (busy_w[i]),
            .done           (done_w[i]),
            .rx_data        (rx_w[i]),
            .ss             (ss_w[i]),
            .sck            (sck_w[i]),
            .mosi           (mosi_w[i]),
            .miso           (miso_w[i])
        );

        assign miso_w[i] = s_sh[15];

        always @(negedge clk) begin
            if (p_ss && !ss_w[i]) begin
                t_fall = cyc;
                nrise  = 0;
                s_sh   = miso_pat[i];
            end
            if (!ss_w[i] && !p_sck && sck_w[i]) begin
                chk("sck_rise_time", cyc - t_fall, H + 2 * H * nrise);
                mo_sh = {mo_sh[14:0], mosi_w[i]};
                nrise++;
            end
            if (!ss_w[i] && p_sck && !sck_w[i]) s_sh = {s_sh[14:0], 1'b0};
            if (done_w[i]) chk("done_at_ss_rise", !p_ss && ss_w[i], 1);
            if (!p_ss && ss_w[i]) begin
                if (done_w[i]) begin
                    chk("sck_rise_count", nrise, 16);
                    chk("frame_expected", exp_q[i].size() != 0, 1);
                    if (exp_q[i].size() != 0) chk("mosi_frame", mo_sh, exp_q[i].pop_front());
                end else begin
                    chk("abort_expected", abort_exp[i], 1);
                end
            end
            p_ss  = ss_w[i];
            p_sck = sck_w[i];
        end
    end

    // One frame on instance i; rej_at >= 0 pulses a rejected request at that relative cycle.
    task automatic frame(input int i, input logic [9:0] s, input logic [3:0] c,
                         input logic [15:0] mp, input logic [15:0] em, input logic [15:0] er,
                         input int rej_at);
        int c0;
        int h;
        int g;
        h = hh(i);
        g = gg(i);
        @(negedge clk);
        smp[i] = s;
        ch[i] = c;
        miso_pat[i] = mp;
        nd[i] = 1'b1;
        exp_q[i].push_back(em);
        c0 = cyc;
        @(negedge clk);
        nd[i] = 1'b0;
        chk("ss_low_cycle1", ss_w[i], 0);
        chk("busy_cycle1", busy_w[i], 1);
        while (done_w[i] !== 1'b1 && cyc - c0 < 4000) begin
            if (cyc - c0 == rej_at) begin
                smp[i] = 10'h3FF;
                nd[i] = 1'b1;
            end else begin
                nd[i] = 1'b0;
            end
            if (cyc - c0 == 33 * h) chk("rx_hold_before_done", rx_w[i], rx_prev[i]);
            @(negedge clk);
        end
        nd[i] = 1'b0;
        chk("done_cycle", cyc - c0, 1 + 33 * h);
        chk("rx_data_at_done", rx_w[i], er);
        rx_prev[i] = er;
        while (busy_w[i] !== 1'b0 && cyc - c0 < 4000) @(negedge clk);
        chk("busy_fall_cycle", cyc - c0, 1 + 33 * h + g);
        @(negedge clk);
    endtask

    typedef struct {
        logic [9:0]  s;
        logic [3:0]  c;
        logic [15:0] mp;
        logic [15:0] em;
        logic [15:0] er;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int hi_start;
        int fall2;
        int lowcnt;
        logic [9:0] rs;
        logic [3:0] rc;
        logic [15:0] rp;

        tbl[0] = '{10'h2A5, 4'h3, 16'hFF5C, 16'hA532, 16'hFF5C};
        tbl[1] = '{10'h001, 4'h0, 16'h0000, 16'h0100, 16'h0000};
        tbl[2] = '{10'h3FF, 4'hF, 16'hA5A5, 16'hFFF3, 16'hA5A5};
        tbl[3] = '{10'h155, 4'hA, 16'h1234, 16'h55A1, 16'h1234};
        tbl[4] = '{10'h2AA, 4'h5, 16'h8001, 16'hAA52, 16'h8001};

        for (int i = 0; i < 3; i++) begin
            nd[i] = 1'b0;
            smp[i] = '0;
            ch[i] = '0;
            rst_v[i] = 1'b1;
            miso_pat[i] = '0;
            rx_prev[i] = '0;
            abort_exp[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        @(negedge clk);
        chk("reset_ss", ss_w[0], 1);
        chk("reset_sck", sck_w[0], 0);
        chk("reset_mosi", mosi_w[0], 0);
        chk("reset_busy", busy_w[0], 0);
        chk("reset_done", done_w[0], 0);
        chk("reset_rx", rx_w[0], 16'h0000);

        for (int j = 0; j < 5; j++) begin
            frame(0, tbl[j].s, tbl[j].c, tbl[j].mp, tbl[j].em, tbl[j].er, (j == 0) ? 40 : -1);
            if (j == 0) begin
                lowcnt = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (ss_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lowcnt++;
                end
                chk("no_second_frame", lowcnt, 0);
            end
        end

        // back-to-back with new_data held high
        @(negedge clk);
        c0 = cyc;
        smp[0] = 10'h001;
        ch[0] = 4'h0;
        miso_pat[0] = 16'h0F0F;
        nd[0] = 1'b1;
        exp_q[0].push_back(16'h0100);
        exp_q[0].push_back(16'hFFF3);
        @(negedge clk);
        smp[0] = 10'h3FF;
        ch[0] = 4'hF;
        while (ss_w[0] !== 1'b1 && cyc - c0 < 4000) @(negedge clk);
        hi_start = cyc - c0;
        chk("b2b_ss_rise", hi_start, 133);
        while (ss_w[0] !== 1'b0 && cyc - c0 < 4000) @(negedge clk);
        fall2 = cyc - c0;
        nd[0] = 1'b0;
        chk("b2b_ss_high_len", fall2 - hi_start, 8 + 2);
        chk("b2b_second_fall", fall2, 143);
        while (done_w[0] !== 1'b1 && cyc - c0 < 4000) @(negedge clk);
        chk("b2b_done2", cyc - c0, 142 + 133);
        chk("b2b_rx", rx_w[0], 16'h0F0F);
        rx_prev[0] = 16'h0F0F;
        while (busy_w[0] !== 1'b0 && cyc - c0 < 4000) @(negedge clk);
        @(negedge clk);

        // reset in the middle of a frame
        @(negedge clk);
        c0 = cyc;
        smp[0] = 10'h0AB;
        ch[0] = 4'h6;
        miso_pat[0] = 16'hFFFF;
        nd[0] = 1'b1;
        @(negedge clk);
        nd[0] = 1'b0;
        while (cyc - c0 < 60) @(negedge clk);
        rst_v[0] = 1'b1;
        abort_exp[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("abort_ss", ss_w[0], 1);
        chk("abort_sck", sck_w[0], 0);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_done", done_w[0], 0);
        chk("abort_rx", rx_w[0], 16'h0000);
        rx_prev[0] = 16'h0000;
        frame(0, 10'h2A5, 4'h3, 16'hC3C3, 16'hA532, 16'hC3C3, -1);
        abort_exp[0] = 1'b0;

        // parameter sweep on the fast and slow instances
        for (int i = 1; i < 3; i++) begin
            for (int f = 0; f < 2; f++) begin
                rs = 10'($urandom_range(0, 1023));
                rc = 4'($urandom_range(0, 15));
                rp = 16'($urandom);
                frame(i, rs, rc, rp, {rs[7:0], rc, 2'b00, rs[9:8]}, rp, -1);
            end
        end

        for (int i = 0; i < 3; i++) chk("queue_drained", exp_q[i].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
